// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational 4x4 multiplier.
// Each operation takes three states: IDLE accepts, MUL computes, DONE waits for the owner's ack.

module fxf_mult (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] acc_s;

    // Shift-and-add over the four partial-product rows
    always_comb begin
        acc_s = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc_s = acc_s + ({4'd0, a} << i);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign p = acc_s;

endmodule

module mult_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [1:0] ack,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [1:0] done,
    output logic [7:0] p
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_r;
    logic       owner_r;
    logic       last_r;
    logic [3:0] op_a_r;
    logic [3:0] op_b_r;
    logic [1:0] gnt_r;
    logic [1:0] done_r;
    logic [7:0] p_r;
    logic       win_s;
    logic [7:0] prod_s;

    fxf_mult u_mult (
        .a (op_a_r),
        .b (op_b_r),
        .p (prod_s)
    );

    // Round-robin pick: a lone requester wins, a tie goes to the non-last owner
    always_comb begin
        win_s = 1'b0;
        case (req)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
    end

    // Operation sequencer with result, grant and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            op_a_r  <= 4'd0;
            op_b_r  <= 4'd0;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            p_r     <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner_r <= win_s;
                        op_a_r  <= win_s ? a1 : a0;
                        op_b_r  <= win_s ? b1 : b0;
                        gnt_r   <= win_s ? 2'b10 : 2'b01;
                        state_r <= MUL;
                    end else begin
                        gnt_r   <= 2'b00;
                    end
                end
                MUL: begin
                    p_r     <= prod_s;
                    done_r  <= owner_r ? 2'b10 : 2'b01;
                    gnt_r   <= 2'b00;
                    state_r <= DONE;
                end
                DONE: begin
                    if (ack[owner_r]) begin
                        done_r  <= 2'b00;
                        last_r  <= owner_r;
                        state_r <= IDLE;
                    end else begin
                        done_r  <= done_r;
                    end
                end
                default: begin
                    gnt_r   <= 2'b00;
                    done_r  <= 2'b00;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign done = done_r;
    assign p    = p_r;
    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: expected grant/product queued at request time, checked at done.

module tb_mult_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] ack;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic [7:0] p;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;
    int   cyc;
    int   last_gnt_cyc;
    logic tb_last;

    mult_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a0   (a0),
        .b0   (b0),
        .a1   (a1),
        .b1   (b1),
        .ack  (ack),
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; ack = 2'b00;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tb_last = 1'b1;
        compared++;
        if (gnt !== 2'b00 || done !== 2'b00 || p !== 8'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: gnt=%b done=%b p=%0d busy=%b, need 00 00 0 0", gnt, done, p, busy);
        end
        // No grant while nobody requests
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_no_req: gnt=%b busy=%b, need 00 0", gnt, busy);
        end
    endtask

    // One full operation; hold keeps req asserted through MUL/DONE
    task automatic run_op(input logic [1:0] r, input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1, input bit hold,
                          input bit chk_gap);
        exp_t e;
        logic own;
        int   n;
        own = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~tb_last;
        e.g = own ? 2'b10 : 2'b01;
        e.p = own ? ({4'd0, x1} * {4'd0, y1}) : ({4'd0, x0} * {4'd0, y0});
        exp_q.push_back(e);
        req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        @(posedge clk);
        #1;
        compared++;
        if (gnt !== e.g) begin
            mismatched++;
            $display("FAIL grant: gnt=%b, need %b", gnt, e.g);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_mul: busy=%b, need 1", busy);
        end
        if (chk_gap) begin
            compared++;
            if (cyc - last_gnt_cyc != 3) begin
                mismatched++;
                $display("FAIL op_period: %0d cycles, need 3", cyc - last_gnt_cyc);
            end
        end
        last_gnt_cyc = cyc;
        if (!hold) req = 2'b00;
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        n = 0;
        while (done === 2'b00 && n < 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        compared++;
        if (n != 1) begin
            mismatched++;
            $display("FAIL done_latency: %0d edges after grant, need 1", n);
        end
        compared++;
        if (done !== e.g || p !== e.p || gnt !== 2'b00) begin
            mismatched++;
            $display("FAIL result: done=%b p=%0d gnt=%b, need %b %0d 00", done, p, gnt, e.g, e.p);
        end
        ack = e.g;
        @(posedge clk);
        #1;
        ack = 2'b00;
        tb_last = own;
        compared++;
        if (done !== 2'b00 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL release: done=%b busy=%b, need 00 0", done, busy);
        end
    endtask

    task automatic test_single();
        run_op(2'b01, 4'd7, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        run_op(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 1'b0, 1'b0);
        run_op(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 4'(i + 2), 4'd11, 4'(i + 9), 4'd6, 1'b1, i != 0);
        end
        req = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stray_ack();
        exp_t e;
        e.g = 2'b01; e.p = 8'd24;
        exp_q.push_back(e);
        req = 2'b01; a0 = 4'd4; b0 = 4'd6;
        @(posedge clk);
        #1;
        req = 2'b00;
        @(posedge clk);
        #1;
        ack = 2'b10; a0 = 4'd15; b0 = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compared++;
        if (done !== e.g || p !== e.p || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL stray_ack: done=%b p=%0d busy=%b, need %b %0d 1", done, p, busy, e.g, e.p);
        end
        ack = 2'b01;
        @(posedge clk);
        #1;
        ack = 2'b00;
        tb_last = 1'b0;
        compared++;
        if (done !== 2'b00 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stray_release: done=%b busy=%b, need 00 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        req = 2'b10; a1 = 4'd13; b1 = 4'd12;
        @(posedge clk);
        #1;
        req = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_last = 1'b1;
        compared++;
        if (done !== 2'b00 || p !== 8'd0 || busy !== 1'b0 || gnt !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_mid: done=%b p=%0d busy=%b gnt=%b, need 00 0 0 00", done, p, busy, gnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done !== 2'b00 || p !== 8'd0) seen = 1'b1;
        end
        compared++;
        if (seen) begin
            mismatched++;
            $display("FAIL reset_no_done: late done/p seen=%b, need 0", seen);
        end
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 256; i++) begin
            run_op(2'b10, 4'd0, 4'd0, 4'(i >> 4), 4'(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0; last_gnt_cyc = 0;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid_op();
        // After an aborted op, a tie must again go to requester 0
        run_op(2'b11, 4'd2, 4'd8, 4'd1, 4'd1, 1'b0, 1'b0);
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
